csr_access_unit: RTL
====================

// Module: csr_access_unit
//
// PURPOSE
// - Initiator side of the CSR file port: executes one Zicsr instruction (CSRRW/S/C, CSRRWI/SI/CI) per request.
// - Drives select/data/load into the CSR file, absorbs its one-cycle registered read latency and does the read-modify-write.
// - Returns the old CSR value for rd to the execute stage. Sits between the decode/execute stage and the CSR file.
//
// PARAMETERS
// - XLEN     32  data width of CSRs and rs1 operand
// - ADDR_W   12  CSR address width
// - CHECK_RO 1   1: writes to addr[11:10]==2'b11 (read-only space) flag illegal; 0: no check
//
// PORTS
// - i_clk         in   1       clock, all state on rising edge
// - i_rst         in   1       reset, asynchronous, active-high
// - i_start       in   1       request strobe; sampled only in IDLE
// - i_funct3      in   3       Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
// - i_csr_addr    in   ADDR_W  CSR address from instruction imm[11:0]
// - i_rs1_field   in   5       rs1 index; also zimm for immediate forms
// - i_rs1_val     in   XLEN    rs1 register value
// - o_busy        out  1       request in flight (state != IDLE)
// - o_done        out  1       one-cycle completion pulse
// - o_rd_data     out  XLEN    old CSR value, valid while o_done
// - o_illegal     out  1       illegal-instruction flag, valid while o_done
// - o_csr_select  out  ADDR_W  to CSR file select
// - o_csr_wdata   out  XLEN    to CSR file write data
// - o_csr_load    out  1       to CSR file write enable
// - i_csr_rdata   in   XLEN    from CSR file registered read output
//
// BEHAVIOUR
// - All outputs registered; reset value 0 for every output, state = IDLE.
// - FSM IDLE -> SEL -> RD -> WR -> IDLE, one cycle per state, no stalls.
// - IDLE: on i_start latch funct3, addr, rs1_field, rs1_val; o_csr_select <= addr; go SEL. Else stay.
// - SEL: CSR file captures selected CSR into i_csr_rdata at this edge; go RD.
// - RD: old = i_csr_rdata; src = funct3[2] ? zero-extended zimm : rs1_val.
//   new = RW: src | RS: old | src | RC: old & ~src.
//   we = (RW/RWI) or (rs1_field != 0). illegal = funct3 in {000,100} or (CHECK_RO and we and addr[11:10]==2'b11).
//   Register: o_csr_wdata <= new, o_csr_load <= we & !illegal, o_rd_data <= illegal ? 0 : old,
//   o_illegal <= illegal, o_done <= 1; go WR.
// - WR: outputs stable, CSR file writes at end of this cycle; at edge o_csr_load, o_done, o_illegal <= 0; go IDLE.
// - Latency: start sampled in cycle 0 -> o_done high in cycle 3; next start accepted in cycle 4. Illegal ops take the same latency.
// - o_busy high in cycles 1..3. i_start while busy is ignored, not queued.
// - o_csr_select holds last address in IDLE. Harmless: reads have no side effects.
// - o_csr_load is high for exactly one cycle per legal writing op; never high outside WR.
// - Reset mid-operation (any state): immediate return to IDLE, outputs 0, no CSR write, no o_done.
//   A reset asserted during WR clears o_csr_load before the edge, so no write occurs.
// - Unimplemented-but-legal addresses: the CSR file returns its stale regout. Not flagged here.
//
// STRUCTURE
// - Package csr_pkg: funct3 localparams (F3_RW..F3_RCI), CSR address constants (MSTATUS 12'h300, MSCRATCH 12'h340,
//   MHARTID 12'hF14, ...), state encoding, is_ro(addr) function.
// - Sub-module csr_alu: combinational (funct3, old, src) -> new value. The FSM and registers stay in csr_access_unit.
//
// TESTING
// - CSRRW 0x340, rs1_val=0xDEADBEEF, mscratch=0x12345678 -> o_done cycle 3, rd=0x12345678,
//   1-cycle load with wdata 0xDEADBEEF; a following CSRRS x0 reads 0xDEADBEEF.
// - CSRRS 0x300 rs1_field=5 rs1_val=0x8, mstatus=0x2 -> wdata 0xA, load=1.
//   Then CSRRS rs1_field=0 -> load never asserted, rd=0xA.
// - CSRRCI 0x304 zimm=3, mie=0xF -> wdata 0xC, rd=0xF. CSRRWI zimm=0 -> load=1, wdata 0.
// - CSRRW 0xF14 -> o_illegal=1, rd=0, no load, mhartid unchanged.
//   funct3=100 -> o_illegal=1 at cycle 3. CSRRS 0xC01 with rs1_field=0 -> legal, rd=time.
// - i_start held high continuously -> ops accepted at cycles 0,4,8; starts during busy cycles have no effect.
// - Assert i_rst in cycle 2 and in cycle 3 of a CSRRW -> all outputs 0 immediately, target CSR unchanged, no o_done.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the Zicsr access path: funct3 codes, well-known CSR
// addresses, FSM encoding and the read-only address-space test.
package csr_pkg;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_TIME     = 12'hC01;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    // Addresses with [11:10] == 2'b11 form the read-only CSR space
    function automatic logic is_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_alu.sv
// Read-modify-write datapath: merges the old CSR value with the source
// operand according to the Zicsr funct3 code.
module csr_alu
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] result_c
);

    always_comb begin
        result_c = old;
        case (funct3)
            F3_RW,  F3_RWI: result_c = src;
            F3_RS,  F3_RSI: result_c = old | src;
            F3_RC,  F3_RCI: result_c = old & ~src;
            default:        result_c = old;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR file port: sequences select, registered read and
// write-back for one Zicsr instruction per request and returns the old value.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 12,
    parameter bit          CHECK_RO = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_csr_addr,
    input  logic [4:0]        i_rs1_field,
    input  logic [XLEN-1:0]   i_rs1_val,
    output logic              o_busy,
    output logic              o_done,
    output logic [XLEN-1:0]   o_rd_data,
    output logic              o_illegal,
    output logic [ADDR_W-1:0] o_csr_select,
    output logic [XLEN-1:0]   o_csr_wdata,
    output logic              o_csr_load,
    input  logic [XLEN-1:0]   i_csr_rdata
);

    state_t            state;
    logic [2:0]        funct3_q;
    logic [4:0]        rs1_field_q;
    logic [XLEN-1:0]   rs1_val_q;

    logic [XLEN-1:0]   src_c;
    logic [XLEN-1:0]   new_val_c;
    logic              we_c;
    logic              illegal_c;

    // o_csr_select doubles as the latched address for the whole operation
    always_comb begin
        src_c     = funct3_q[2] ? XLEN'(rs1_field_q) : rs1_val_q;
        we_c      = (funct3_q[1:0] == 2'b01) || (rs1_field_q != 5'd0);
        illegal_c = (funct3_q[1:0] == 2'b00)
                 || (CHECK_RO && we_c && is_ro(12'(o_csr_select)));
    end

    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3   (funct3_q),
        .old      (i_csr_rdata),
        .src      (src_c),
        .result_c (new_val_c)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            funct3_q     <= 3'd0;
            rs1_field_q  <= 5'd0;
            rs1_val_q    <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_rd_data    <= '0;
            o_illegal    <= 1'b0;
            o_csr_select <= '0;
            o_csr_wdata  <= '0;
            o_csr_load   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        funct3_q     <= i_funct3;
                        rs1_field_q  <= i_rs1_field;
                        rs1_val_q    <= i_rs1_val;
                        o_csr_select <= i_csr_addr;
                        o_busy       <= 1'b1;
                        state        <= ST_SEL;
                    end
                end
                // CSR file registers the selected value at this edge
                ST_SEL: state <= ST_RD;
                ST_RD: begin
                    o_csr_wdata <= new_val_c;
                    o_csr_load  <= we_c & ~illegal_c;
                    o_rd_data   <= illegal_c ? '0 : i_csr_rdata;
                    o_illegal   <= illegal_c;
                    o_done      <= 1'b1;
                    state       <= ST_WR;
                end
                ST_WR: begin
                    o_csr_load <= 1'b0;
                    o_done     <= 1'b0;
                    o_illegal  <= 1'b0;
                    o_busy     <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
